// File: rtl/product_spi_tx.sv
// SPI mode-0 transmitter: drives the product mux select and shifts NUM_WORDS words MSB-first.
// Optional macro SPI_PARITY_EN appends an even-parity bit after each word.
module product_spi_tx #(
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned NUM_WORDS = 2,
  parameter int unsigned CLK_DIV   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [WORD_W-1:0] mux_in,
  output logic              clk_sel,
  output logic              sclk,
  output logic              mosi,
  output logic              cs_n,
  output logic              busy,
  output logic              done
);

`ifdef SPI_PARITY_EN
  localparam int unsigned LAST_BIT = WORD_W;
`else
  localparam int unsigned LAST_BIT = WORD_W - 1;
`endif
  localparam int unsigned BIT_CW  = $clog2(LAST_BIT + 2);
  localparam int unsigned DIV_CW  = $clog2(CLK_DIV + 1);
  localparam int unsigned WORD_CW = $clog2(NUM_WORDS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LOW,
    S_HIGH,
    S_DONE
  } state_t;

  state_t              r_state,    w_state_nxt;
  logic [WORD_W-1:0]   r_shreg,    w_shreg_nxt;
  logic [BIT_CW-1:0]   r_bit_cnt,  w_bit_cnt_nxt;
  logic [DIV_CW-1:0]   r_div_cnt,  w_div_cnt_nxt;
  logic [WORD_CW-1:0]  r_word_cnt, w_word_cnt_nxt;
  logic                r_clk_sel,  w_clk_sel_nxt;
  logic                r_sclk,     w_sclk_nxt;
  logic                r_mosi,     w_mosi_nxt;
  logic                r_cs_n,     w_cs_n_nxt;
  logic                r_busy,     w_busy_nxt;
  logic                r_done,     w_done_nxt;
`ifdef SPI_PARITY_EN
  logic                r_par,      w_par_nxt;
`endif
  logic                w_div_last;

  assign w_div_last = (r_div_cnt == DIV_CW'(CLK_DIV - 1));

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_shreg    <= '0;
      r_bit_cnt  <= '0;
      r_div_cnt  <= '0;
      r_word_cnt <= '0;
      r_clk_sel  <= 1'b0;
      r_sclk     <= 1'b0;
      r_mosi     <= 1'b0;
      r_cs_n     <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
`ifdef SPI_PARITY_EN
      r_par      <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_shreg    <= w_shreg_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_div_cnt  <= w_div_cnt_nxt;
      r_word_cnt <= w_word_cnt_nxt;
      r_clk_sel  <= w_clk_sel_nxt;
      r_sclk     <= w_sclk_nxt;
      r_mosi     <= w_mosi_nxt;
      r_cs_n     <= w_cs_n_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
`ifdef SPI_PARITY_EN
      r_par      <= w_par_nxt;
`endif
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt    = r_state;
    w_shreg_nxt    = r_shreg;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_div_cnt_nxt  = r_div_cnt;
    w_word_cnt_nxt = r_word_cnt;
    w_clk_sel_nxt  = r_clk_sel;
    w_sclk_nxt     = r_sclk;
    w_mosi_nxt     = r_mosi;
    w_cs_n_nxt     = r_cs_n;
    w_busy_nxt     = r_busy;
    w_done_nxt     = 1'b0;
`ifdef SPI_PARITY_EN
    w_par_nxt      = r_par;
`endif
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_cs_n_nxt  = 1'b0;
          w_busy_nxt  = 1'b1;
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        w_shreg_nxt   = mux_in;
        w_mosi_nxt    = mux_in[WORD_W-1];
        w_bit_cnt_nxt = '0;
        w_div_cnt_nxt = '0;
`ifdef SPI_PARITY_EN
        w_par_nxt     = ^mux_in;
`endif
        w_state_nxt   = S_LOW;
      end
      S_LOW: begin
        if (w_div_last) begin
          w_div_cnt_nxt = '0;
          w_sclk_nxt    = 1'b1;
          w_state_nxt   = S_HIGH;
        end else begin
          w_div_cnt_nxt = r_div_cnt + DIV_CW'(1);
        end
      end
      S_HIGH: begin
        if (w_div_last) begin
          w_div_cnt_nxt = '0;
          w_sclk_nxt    = 1'b0;
          if (r_bit_cnt != BIT_CW'(LAST_BIT)) begin
            // mosi only moves on the sclk falling transition
            w_shreg_nxt   = r_shreg << 1;
            w_mosi_nxt    = w_shreg_nxt[WORD_W-1];
`ifdef SPI_PARITY_EN
            if (r_bit_cnt == BIT_CW'(WORD_W - 1)) w_mosi_nxt = r_par;
`endif
            w_bit_cnt_nxt = r_bit_cnt + BIT_CW'(1);
            w_state_nxt   = S_LOW;
          end else if (r_word_cnt != WORD_CW'(NUM_WORDS - 1)) begin
            w_word_cnt_nxt = r_word_cnt + WORD_CW'(1);
            w_clk_sel_nxt  = w_word_cnt_nxt[0];
            w_state_nxt    = S_LOAD;
          end else begin
            w_state_nxt = S_DONE;
          end
        end else begin
          w_div_cnt_nxt = r_div_cnt + DIV_CW'(1);
        end
      end
      S_DONE: begin
        w_cs_n_nxt     = 1'b1;
        w_busy_nxt     = 1'b0;
        w_done_nxt     = 1'b1;
        w_clk_sel_nxt  = 1'b0;
        w_word_cnt_nxt = '0;
        w_state_nxt    = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign clk_sel = r_clk_sel;
  assign sclk    = r_sclk;
  assign mosi    = r_mosi;
  assign cs_n    = r_cs_n;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule

// File: tb/tb_product_spi_tx.sv
// Bench for product_spi_tx: a modelled SPI slave and product mux, two instances (CLK_DIV 4 and 1).
`timescale 1ns/1ps
module tb_product_spi_tx;

  localparam int WORD_W    = 32;
  localparam int NUM_WORDS = 2;
`ifdef SPI_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int WB   = WORD_W + PAR;
  localparam int LAT4 = 2 + NUM_WORDS * (1 + 2 * WB * 4);
  localparam int LAT1 = 2 + NUM_WORDS * (1 + 2 * WB * 1);

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start0 = 1'b0, start1 = 1'b0;
  logic [31:0] msb0 = '0, lsb0 = '0, msb1 = '0, lsb1 = '0;
  logic [31:0] mux0, mux1;
  logic clk_sel0, sclk0, mosi0, cs_n0, busy0, done0;
  logic clk_sel1, sclk1, mosi1, cs_n1, busy1, done1;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  assign mux0 = clk_sel0 ? lsb0 : msb0;
  assign mux1 = clk_sel1 ? lsb1 : msb1;

  product_spi_tx #(.WORD_W(32), .NUM_WORDS(2), .CLK_DIV(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .mux_in(mux0), .clk_sel(clk_sel0),
    .sclk(sclk0), .mosi(mosi0), .cs_n(cs_n0), .busy(busy0), .done(done0));

  product_spi_tx #(.WORD_W(32), .NUM_WORDS(2), .CLK_DIV(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .mux_in(mux1), .clk_sel(clk_sel1),
    .sclk(sclk1), .mosi(mosi1), .cs_n(cs_n1), .busy(busy1), .done(done1));

  // Slave model: captures mosi on each sclk rising edge and records protocol anomalies
  bit   cap0[$];
  bit   cap1[$];
  int   rise_n[2];
  int   done_n[2];
  int   long_done[2];
  int   sel_rise_at[2];
  int   hi_viol[2];
  int   cs_viol[2];
  logic [1:0] p_sclk = '0, p_mosi = '0, p_done = '0, p_sel = '0;

  always @(negedge clk) begin
    logic [1:0] v_sclk, v_mosi, v_cs, v_done, v_sel;
    v_sclk = {sclk1, sclk0};
    v_mosi = {mosi1, mosi0};
    v_cs   = {cs_n1, cs_n0};
    v_done = {done1, done0};
    v_sel  = {clk_sel1, clk_sel0};
    for (int k = 0; k < 2; k++) begin
      if (v_sclk[k] && !p_sclk[k]) begin
        rise_n[k]++;
        if (k == 0) cap0.push_back(v_mosi[k]);
        else        cap1.push_back(v_mosi[k]);
        if (v_cs[k]) cs_viol[k]++;
      end
      if (v_sclk[k] && p_sclk[k] && (v_mosi[k] != p_mosi[k])) hi_viol[k]++;
      if (v_done[k]) begin
        if (p_done[k]) long_done[k]++;
        else           done_n[k]++;
      end
      if (v_sel[k] && !p_sel[k]) sel_rise_at[k] = rise_n[k];
    end
    p_sclk = v_sclk;
    p_mosi = v_mosi;
    p_done = v_done;
    p_sel  = v_sel;
  end

  function automatic logic [31:0] get_word(input int k, input int pos);
    logic [31:0] w = '0;
    for (int i = 0; i < WORD_W; i++)
      w = {w[30:0], (k == 0) ? cap0[pos+i] : cap1[pos+i]};
    return w;
  endfunction

  function automatic logic get_bit(input int k, input int pos);
    return (k == 0) ? cap0[pos] : cap1[pos];
  endfunction

  // Pulses start0 once (plus an optional stray start at cycle extra_at); lat = -1 on timeout
  task automatic run_frame0(input logic [31:0] m, input logic [31:0] l, input int extra_at,
                            output int lat, output int hi_cyc);
    msb0 = m; lsb0 = l; lat = -1; hi_cyc = 0;
    @(posedge clk); #1; start0 = 1'b1;
    for (int n = 1; n <= 3000; n++) begin
      @(posedge clk); #1;
      if (n == 1) start0 = 1'b0;
      if (extra_at > 0 && n == extra_at - 1) start0 = 1'b1;
      if (extra_at > 0 && n == extra_at) start0 = 1'b0;
      if (sclk0) hi_cyc++;
      if (done0) begin
        lat = n;
        break;
      end
    end
    start0 = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (clk_sel0 !== 1'b0) $display("FAIL reset_clk_sel: got %b expected 0", clk_sel0); else passed++;
    checks++; if (sclk0 !== 1'b0) $display("FAIL reset_sclk: got %b expected 0", sclk0); else passed++;
    checks++; if (mosi0 !== 1'b0) $display("FAIL reset_mosi: got %b expected 0", mosi0); else passed++;
    checks++; if (cs_n0 !== 1'b1) $display("FAIL reset_cs_n: got %b expected 1", cs_n0); else passed++;
    checks++; if (busy0 !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy0); else passed++;
    checks++; if (done0 !== 1'b0) $display("FAIL reset_done: got %b expected 0", done0); else passed++;
    checks++; if (cs_n1 !== 1'b1) $display("FAIL reset_cs_n1: got %b expected 1", cs_n1); else passed++;
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_single_frame();
    int lat, hi, br, bq, bd, bh, bc, bl;
    logic [31:0] m = 32'hDEADBEEF, l = 32'h12345678;
    br = rise_n[0]; bq = cap0.size(); bd = done_n[0]; bh = hi_viol[0]; bc = cs_viol[0]; bl = long_done[0];
    run_frame0(m, l, 0, lat, hi);
    checks++; if (clk_sel0 !== 1'b0) $display("FAIL single_clk_sel_at_done: got %b expected 0", clk_sel0); else passed++;
    checks++; if (busy0 !== 1'b0) $display("FAIL single_busy_at_done: got %b expected 0", busy0); else passed++;
    checks++; if (cs_n0 !== 1'b1) $display("FAIL single_cs_n_at_done: got %b expected 1", cs_n0); else passed++;
    @(negedge clk); #1;
    checks++; if (lat !== LAT4) $display("FAIL single_latency: got %0d expected %0d", lat, LAT4); else passed++;
    checks++; if (rise_n[0] - br !== NUM_WORDS * WB) $display("FAIL single_rises: got %0d expected %0d", rise_n[0] - br, NUM_WORDS * WB); else passed++;
    checks++; if (hi !== NUM_WORDS * WB * 4) $display("FAIL single_sclk_high_cycles: got %0d expected %0d", hi, NUM_WORDS * WB * 4); else passed++;
    checks++; if (get_word(0, bq) !== m) $display("FAIL single_word0: got %h expected %h", get_word(0, bq), m); else passed++;
    checks++; if (get_word(0, bq + WB) !== l) $display("FAIL single_word1: got %h expected %h", get_word(0, bq + WB), l); else passed++;
    checks++; if (sel_rise_at[0] - br !== WB) $display("FAIL single_clk_sel_switch: got %0d expected %0d", sel_rise_at[0] - br, WB); else passed++;
    checks++; if (cs_viol[0] - bc !== 0) $display("FAIL single_cs_n_low: got %0d expected 0", cs_viol[0] - bc); else passed++;
    checks++; if (hi_viol[0] - bh !== 0) $display("FAIL single_mosi_stable: got %0d expected 0", hi_viol[0] - bh); else passed++;
    checks++; if (done_n[0] - bd !== 1) $display("FAIL single_done_count: got %0d expected 1", done_n[0] - bd); else passed++;
    checks++; if (long_done[0] - bl !== 0) $display("FAIL single_done_width: got %0d expected 0", long_done[0] - bl); else passed++;
  endtask

  task automatic test_parity_pattern();
    int lat, hi, br, bq;
    logic [31:0] m = 32'h00000007, l = 32'h00000003;
    br = rise_n[0]; bq = cap0.size();
    run_frame0(m, l, 0, lat, hi);
    @(negedge clk); #1;
    checks++; if (lat !== LAT4) $display("FAIL parity_latency: got %0d expected %0d", lat, LAT4); else passed++;
    checks++; if (rise_n[0] - br !== NUM_WORDS * WB) $display("FAIL parity_rises: got %0d expected %0d", rise_n[0] - br, NUM_WORDS * WB); else passed++;
    checks++; if (get_word(0, bq) !== m) $display("FAIL parity_word0: got %h expected %h", get_word(0, bq), m); else passed++;
    checks++; if (get_word(0, bq + WB) !== l) $display("FAIL parity_word1: got %h expected %h", get_word(0, bq + WB), l); else passed++;
`ifdef SPI_PARITY_EN
    checks++; if (get_bit(0, bq + WORD_W) !== ^m) $display("FAIL parity_bit0: got %b expected %b", get_bit(0, bq + WORD_W), ^m); else passed++;
    checks++; if (get_bit(0, bq + WB + WORD_W) !== ^l) $display("FAIL parity_bit1: got %b expected %b", get_bit(0, bq + WB + WORD_W), ^l); else passed++;
`endif
  endtask

  task automatic test_random_frames();
    int lat, hi, bq;
    logic [31:0] m, l;
    for (int t = 0; t < 3; t++) begin
      m = $urandom; l = $urandom;
      bq = cap0.size();
      run_frame0(m, l, 0, lat, hi);
      @(negedge clk); #1;
      checks++; if (lat !== LAT4) $display("FAIL rand%0d_latency: got %0d expected %0d", t, lat, LAT4); else passed++;
      checks++; if (get_word(0, bq) !== m) $display("FAIL rand%0d_word0: got %h expected %h", t, get_word(0, bq), m); else passed++;
      checks++; if (get_word(0, bq + WB) !== l) $display("FAIL rand%0d_word1: got %h expected %h", t, get_word(0, bq + WB), l); else passed++;
`ifdef SPI_PARITY_EN
      checks++; if (get_bit(0, bq + WORD_W) !== ^m) $display("FAIL rand%0d_parity0: got %b expected %b", t, get_bit(0, bq + WORD_W), ^m); else passed++;
`endif
    end
  endtask

  task automatic test_start_during_busy();
    int lat, hi, br, bd;
    logic [31:0] m, l;
    m = $urandom; l = $urandom;
    br = rise_n[0]; bd = done_n[0];
    run_frame0(m, l, 100, lat, hi);
    repeat (LAT4 + 50) @(posedge clk);
    @(negedge clk); #1;
    checks++; if (lat !== LAT4) $display("FAIL busy_start_latency: got %0d expected %0d", lat, LAT4); else passed++;
    checks++; if (rise_n[0] - br !== NUM_WORDS * WB) $display("FAIL busy_start_rises: got %0d expected %0d", rise_n[0] - br, NUM_WORDS * WB); else passed++;
    checks++; if (done_n[0] - bd !== 1) $display("FAIL busy_start_done_count: got %0d expected 1", done_n[0] - bd); else passed++;
    checks++; if (busy0 !== 1'b0) $display("FAIL busy_start_idle: got %b expected 0", busy0); else passed++;
  endtask

  task automatic test_reset_mid_frame();
    int lat, hi, br, bq, bd;
    logic [31:0] m, l;
    bd = done_n[0];
    msb0 = $urandom; lsb0 = $urandom;
    @(posedge clk); #1; start0 = 1'b1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      if (n == 1) start0 = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    checks++; if (cs_n0 !== 1'b1) $display("FAIL midreset_cs_n: got %b expected 1", cs_n0); else passed++;
    checks++; if (sclk0 !== 1'b0) $display("FAIL midreset_sclk: got %b expected 0", sclk0); else passed++;
    checks++; if (busy0 !== 1'b0) $display("FAIL midreset_busy: got %b expected 0", busy0); else passed++;
    checks++; if (mosi0 !== 1'b0) $display("FAIL midreset_mosi: got %b expected 0", mosi0); else passed++;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    checks++; if (done_n[0] - bd !== 0) $display("FAIL midreset_no_done: got %0d expected 0", done_n[0] - bd); else passed++;
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (2) @(posedge clk);
    m = $urandom; l = $urandom;
    br = rise_n[0]; bq = cap0.size();
    run_frame0(m, l, 0, lat, hi);
    @(negedge clk); #1;
    checks++; if (lat !== LAT4) $display("FAIL postreset_latency: got %0d expected %0d", lat, LAT4); else passed++;
    checks++; if (rise_n[0] - br !== NUM_WORDS * WB) $display("FAIL postreset_rises: got %0d expected %0d", rise_n[0] - br, NUM_WORDS * WB); else passed++;
    checks++; if (get_word(0, bq) !== m) $display("FAIL postreset_word0: got %h expected %h", get_word(0, bq), m); else passed++;
    checks++; if (get_word(0, bq + WB) !== l) $display("FAIL postreset_word1: got %h expected %h", get_word(0, bq + WB), l); else passed++;
  endtask

  task automatic test_back_to_back_div1();
    int d1 = 0, d2 = 0, gap = 0, hi = 0, br, bq, bh;
    bit gap_done = 1'b0;
    logic [31:0] m = 32'hFFFFFFFF, l = 32'h00000001;
    msb1 = m; lsb1 = l;
    br = rise_n[1]; bq = cap1.size(); bh = hi_viol[1];
    @(posedge clk); #1; start1 = 1'b1;
    for (int n = 1; n <= 1000; n++) begin
      @(posedge clk); #1;
      if (n == 140) start1 = 1'b0;
      if (d1 == 0 && sclk1) hi++;
      if (done1) begin
        if (d1 == 0) d1 = n;
        else d2 = n;
      end
      if (d1 > 0 && !gap_done) begin
        if (cs_n1) gap++;
        else gap_done = 1'b1;
      end
      if (d2 > 0) break;
    end
    start1 = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk); #1;
    checks++; if (d1 !== LAT1) $display("FAIL b2b_done1: got %0d expected %0d", d1, LAT1); else passed++;
    checks++; if (d2 !== 2 * LAT1) $display("FAIL b2b_done2: got %0d expected %0d", d2, 2 * LAT1); else passed++;
    checks++; if (gap !== 1) $display("FAIL b2b_cs_gap: got %0d expected 1", gap); else passed++;
    checks++; if (hi !== NUM_WORDS * WB) $display("FAIL b2b_sclk_high_cycles: got %0d expected %0d", hi, NUM_WORDS * WB); else passed++;
    checks++; if (rise_n[1] - br !== 2 * NUM_WORDS * WB) $display("FAIL b2b_rises: got %0d expected %0d", rise_n[1] - br, 2 * NUM_WORDS * WB); else passed++;
    checks++; if (get_word(1, bq) !== m) $display("FAIL b2b_f1_word0: got %h expected %h", get_word(1, bq), m); else passed++;
    checks++; if (get_word(1, bq + WB) !== l) $display("FAIL b2b_f1_word1: got %h expected %h", get_word(1, bq + WB), l); else passed++;
    checks++; if (get_word(1, bq + 2 * WB) !== m) $display("FAIL b2b_f2_word0: got %h expected %h", get_word(1, bq + 2 * WB), m); else passed++;
    checks++; if (get_word(1, bq + 3 * WB) !== l) $display("FAIL b2b_f2_word1: got %h expected %h", get_word(1, bq + 3 * WB), l); else passed++;
    checks++; if (hi_viol[1] - bh !== 0) $display("FAIL b2b_mosi_stable: got %0d expected 0", hi_viol[1] - bh); else passed++;
    checks++; if (busy1 !== 1'b0) $display("FAIL b2b_idle_after: got %b expected 0", busy1); else passed++;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_parity_pattern();
    test_random_frames();
    test_start_during_busy();
    test_reset_mid_frame();
    test_back_to_back_div1();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
